instr_loader: RTL and testbench



---
 rtl/instr_loader.sv | 114 +++++++++++
 tb/tb_instr_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: streams host instruction words into the instruction memory
// write port, then pulses start to launch the core. Keeps a running mod-2^32
// checksum of the words accepted in the current session.
module instr_loader #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW:0]   ld_len,
    input  logic          wr_valid,
    input  logic [31:0]   wr_data,
    output logic          wr_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          start,
    output logic          err,
    output logic [31:0]   checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t      state;
    logic [AW:0] len;
    logic [AW:0] idx;
    logic        xfer;
    logic        len_ok;
    logic [31:0] word_off;

    // Handshake, length validation and word-to-byte offset
    always_comb begin
        xfer     = (state == S_LOAD) && wr_valid && wr_ready;
        len_ok   = (ld_len != '0) && (ld_len <= DEPTH_L);
        word_off = 32'({idx[AW-1:0], 2'b00});
    end

    // Session FSM with registered handshake, memory port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len       <= '0;
            idx       <= '0;
            wr_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start     <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
        end else begin
            mem_we <= 1'b0;
            start  <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (ld_en) begin
                        if (!len_ok) begin
                            err <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            checksum <= '0;
                            len      <= ld_len;
                            idx      <= '0;
                            wr_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE + word_off;
                        mem_wdata <= wr_data;
                        checksum  <= checksum + wr_data;
                        idx       <= idx + 1'b1;
                        if (idx == len - 1'b1) begin
                            wr_ready <= 1'b0;
                            state    <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    start <= 1'b1;
                    state <= S_START;
                end
                S_START: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized and directed sessions against a queue-based
// scoreboard of expected memory writes and start pulses.
module tb_instr_loader;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          ld_en;
    logic [AW:0]   ld_len;
    logic          wr_valid;
    logic [31:0]   wr_data;
    logic          wr_ready;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          start;
    logic          err;
    logic [31:0]   checksum;

    instr_loader #(.DEPTH(DEPTH), .AW(AW), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_len(ld_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .start(start), .err(err),
        .checksum(checksum)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         wq[$];
    int          start_q[$];
    logic [31:0] words[$];
    logic [31:0] exp_sum;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle, the write port and start must match the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                chk("mem_we", {31'b0, mem_we}, 32'd1);
                chk("mem_addr", mem_addr, wq[0].addr);
                chk("mem_wdata", mem_wdata, wq[0].data);
                void'(wq.pop_front());
            end else begin
                chk("mem_we_quiet", {31'b0, mem_we}, 32'd0);
            end
            if (start_q.size() > 0 && start_q[0] == cyc) begin
                chk("start_pulse", {31'b0, start}, 32'd1);
                void'(start_q.pop_front());
            end else begin
                chk("start_quiet", {31'b0, start}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1; ld_en = 1'b0; wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_session(input int len);
        ld_en = 1'b1; ld_len = (AW+1)'(len);
        exp_sum = '0;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic bad_len(input int len, input logic exp_done, input logic [31:0] exp_ck);
        ld_en = 1'b1; ld_len = (AW+1)'(len);
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
        chk("bad_err", {31'b0, err}, 32'd1);
        chk("bad_ready", {31'b0, wr_ready}, 32'd0);
        chk("bad_busy", {31'b0, busy}, 32'd0);
        chk("bad_done", {31'b0, done}, {31'b0, exp_done});
        chk("bad_checksum", checksum, exp_ck);
        @(posedge clk);
        #1;
    endtask

    // Drives `count` words of `words`; expectations derived from word order
    task automatic stream(input int count, input int len, input int pct,
                          input logic [31:0] pat, input int pat_len,
                          input bit mid, output int last_edge);
        int  i = 0;
        int  budget = 0;
        bit  v;
        last_edge = -1;
        while (i < count && budget < 2000) begin
            if (budget < pat_len) v = pat[budget];
            else                  v = ($urandom_range(99) < pct);
            wr_valid = v;
            wr_data  = v ? words[i] : $urandom();
            if (mid) begin
                ld_en  = (budget == 1);
                ld_len = 6'd1;
            end
            @(negedge clk);
            if (budget == 0) begin
                chk("load_ready", {31'b0, wr_ready}, 32'd1);
                chk("load_busy", {31'b0, busy}, 32'd1);
                chk("load_err", {31'b0, err}, 32'd0);
                chk("load_ck0", checksum, 32'd0);
            end
            if (v && wr_ready) begin
                wq.push_back('{BASE + 32'(4 * i), words[i], cyc + 1});
                exp_sum += words[i];
                last_edge = cyc + 1;
                i++;
                if (i == len) start_q.push_back(cyc + 2);
            end
            @(posedge clk);
            #1;
            budget++;
        end
        wr_valid = 1'b0;
        ld_en    = 1'b0;
        checks++;
        if (i != count) begin
            errors++;
            $display("FAIL stream_timeout actual=%0d required=%0d words", i, count);
        end
    endtask

    task automatic finish_session();
        @(negedge clk);
        chk("flush_ready", {31'b0, wr_ready}, 32'd0);
        chk("flush_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("done", {31'b0, done}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd0);
        chk("checksum", checksum, exp_sum);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int k = 0; k < n; k++) words.push_back($urandom());
    endtask

    initial begin
        int last;
        int len;
        ld_len = '0; wr_data = '0; exp_sum = '0;
        do_reset();
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_ready", {31'b0, wr_ready}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, BASE);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back four-word program
        words = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};
        start_session(4);
        stream(4, 4, 100, '0, 0, 1'b0, last);
        finish_session();

        // Stalled stream 1,0,0,1,0,1
        fill_random(3);
        start_session(3);
        stream(3, 3, 100, 32'b101001, 6, 1'b0, last);
        finish_session();

        // Bad lengths from DONE, then from IDLE, then a valid length clears err
        bad_len(0, 1'b1, exp_sum);
        do_reset();
        bad_len(0, 1'b0, 32'd0);
        bad_len(DEPTH + 1, 1'b0, 32'd0);
        fill_random(1);
        start_session(1);
        stream(1, 1, 100, '0, 0, 1'b0, last);
        finish_session();

        // Full-depth image, last write at BASE + 0x7C
        fill_random(DEPTH);
        start_session(DEPTH);
        stream(DEPTH, DEPTH, 100, '0, 0, 1'b0, last);
        finish_session();

        // Reset after the second of four words
        fill_random(4);
        start_session(4);
        stream(2, 4, 100, '0, 0, 1'b0, last);
        rst = 1'b1; wr_valid = 1'b1; wr_data = words[2];
        @(posedge clk);
        #1 rst = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'b0, wr_ready}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_checksum", checksum, 32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;

        // Reach DONE, then a new two-word session with a stray ld_en mid-load
        fill_random(3);
        start_session(3);
        stream(3, 3, 80, '0, 0, 1'b0, last);
        finish_session();
        fill_random(2);
        start_session(2);
        stream(2, 2, 70, 32'b1, 1, 1'b1, last);
        finish_session();

        // Randomized sessions
        for (int s = 0; s < 8; s++) begin
            len = int'($urandom_range(DEPTH, 1));
            fill_random(len);
            start_session(len);
            stream(len, len, int'($urandom_range(100, 40)), '0, 0, 1'b0, last);
            finish_session();
            repeat (int'($urandom_range(3))) @(posedge clk);
            #1;
        end

        repeat (4) @(negedge clk);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("start_q_drained", 32'(start_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
